// File: rtl/rptr_level_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : rptr_level_ctrl_if
// Brief   : Read-side FIFO bus between the pointer/level controller and its peers.
// Revision: 1.0
// ============================================================================
interface rptr_level_ctrl_if #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
);
    logic                  rinc;
    logic [ADDRSIZE:0]     rq2_wptr;
    logic [ADDRSIZE+1:0]   rthresh;
    logic                  rclr_err;
    logic [DATASIZE-1:0]   rmem_data;
    logic [ADDRSIZE-1:0]   raddr;
    logic [ADDRSIZE:0]     rptr;
    logic [DATASIZE-1:0]   rdata;
    logic                  rvalid;
    logic                  rempty;
    logic                  rarempty;
    logic [ADDRSIZE+1:0]   rlevel;
    logic                  runderflow;

    modport slave (
        input  rinc, rq2_wptr, rthresh, rclr_err, rmem_data,
        output raddr, rptr, rdata, rvalid, rempty, rarempty, rlevel, runderflow
    );

    modport master (
        output rinc, rq2_wptr, rthresh, rclr_err, rmem_data,
        input  raddr, rptr, rdata, rvalid, rempty, rarempty, rlevel, runderflow
    );
endinterface
`default_nettype wire

// File: rtl/rptr_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rptr_level_ctrl
// Brief   : Async-FIFO read pointer, fill level, almost-empty, underflow, FWFT.
// Revision: 1.0
// ============================================================================
module rptr_level_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8,
    parameter int FWFT     = 0
) (
    input  wire logic        rclk,
    input  wire logic        rrst_n,
    rptr_level_ctrl_if.slave bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam int LW = ADDRSIZE + 2;

    logic [PW-1:0]       rbin_q, rbin_d, rptr_q, rgray_d, wbin;
    logic                mem_empty_q, mem_empty_d;
    logic                pop, rvalid, lvl_inc;
    logic [LW-1:0]       memlvl_d, level_d, rlevel_q;
    logic                rarempty_q, rarempty_d;
    logic                runderflow_q, runderflow_d;
    logic [DATASIZE-1:0] rdata;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    assign rbin_d       = rbin_q + {{(PW-1){1'b0}}, pop};
    assign rgray_d      = (rbin_d >> 1) ^ rbin_d;
    assign mem_empty_d  = (rgray_d == bus.rq2_wptr);
    assign memlvl_d     = {1'b0, wbin - rbin_d};
    assign level_d      = memlvl_d + {{(LW-1){1'b0}}, lvl_inc};
    assign rarempty_d   = (level_d <= bus.rthresh);
    // A pop request against an empty user view sets the flag; set beats clear
    assign runderflow_d = (bus.rinc & ~rvalid) | (runderflow_q & ~bus.rclr_err);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            mem_empty_q  <= 1'b1;
            rlevel_q     <= '0;
            rarempty_q   <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rgray_d;
            mem_empty_q  <= mem_empty_d;
            rlevel_q     <= level_d;
            rarempty_q   <= rarempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            typedef enum logic [0:0] {
                S_IDLE = 1'b0,
                S_FULL = 1'b1
            } state_t;

            state_t              state_q, state_d;
            logic [DATASIZE-1:0] rdata_q, rdata_d;
            logic                pop_w;

            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    state_q <= S_IDLE;
                    rdata_q <= '0;
                end else begin
                    state_q <= state_d;
                    rdata_q <= rdata_d;
                end
            end

            // Staged word is replaced in the same cycle it is consumed, so no bubble
            always_comb begin
                state_d = state_q;
                rdata_d = rdata_q;
                pop_w   = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (!mem_empty_q) begin
                            pop_w   = 1'b1;
                            rdata_d = bus.rmem_data;
                            state_d = S_FULL;
                        end
                    end
                    S_FULL: begin
                        if (bus.rinc) begin
                            if (!mem_empty_q) begin
                                pop_w   = 1'b1;
                                rdata_d = bus.rmem_data;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            assign pop     = pop_w;
            assign rvalid  = (state_q == S_FULL);
            assign lvl_inc = (state_d == S_FULL);
            assign rdata   = rdata_q;
        end else begin : g_std
            assign pop     = bus.rinc & ~mem_empty_q;
            assign rvalid  = ~mem_empty_q;
            assign lvl_inc = 1'b0;
            assign rdata   = bus.rmem_data;
        end
    endgenerate

    assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rdata      = rdata;
    assign bus.rvalid     = rvalid;
    assign bus.rempty     = ~rvalid;
    assign bus.rarempty   = rarempty_q;
    assign bus.rlevel     = rlevel_q;
    assign bus.runderflow = runderflow_q;
endmodule
`default_nettype wire

// File: tb/tb_rptr_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rptr_level_ctrl
// Brief   : Directed vectors for the standard and FWFT read controllers.
// Revision: 1.0
// ============================================================================
module tb_rptr_level_ctrl;
    logic rclk = 1'b0;
    logic rst0_n, rst1_n;
    logic [7:0] mem [16];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 rclk = ~rclk;

    rptr_level_ctrl_if #(.ADDRSIZE(4), .DATASIZE(8)) if0 ();
    rptr_level_ctrl_if #(.ADDRSIZE(4), .DATASIZE(8)) if1 ();

    assign if0.rmem_data = mem[if0.raddr];
    assign if1.rmem_data = mem[if1.raddr];

    rptr_level_ctrl #(.ADDRSIZE(4), .DATASIZE(8), .FWFT(0)) u_std (
        .rclk(rclk), .rrst_n(rst0_n), .bus(if0.slave));
    rptr_level_ctrl #(.ADDRSIZE(4), .DATASIZE(8), .FWFT(1)) u_fwft (
        .rclk(rclk), .rrst_n(rst1_n), .bus(if1.slave));

    typedef struct {
        logic [4:0] wb;
        logic       inc;
        logic       clr;
        logic [5:0] th;
        logic [4:0] rb;
        logic       e;
        logic [5:0] lvl;
        logic       a;
        logic       u;
    } vec_t;

    vec_t vt [23];

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input int wb, inc, clr, th, rb, e, lvl, a, u);
        vec_t v;
        v.wb = 5'(wb); v.inc = 1'(inc); v.clr = 1'(clr); v.th = 6'(th);
        v.rb = 5'(rb); v.e = 1'(e); v.lvl = 6'(lvl); v.a = 1'(a); v.u = 1'(u);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic step0(input logic [4:0] wb, input logic inc, clr, input logic [5:0] th);
        @(negedge rclk);
        if0.rq2_wptr = g(wb); if0.rinc = inc; if0.rclr_err = clr; if0.rthresh = th;
        @(posedge rclk); #1;
    endtask

    task automatic step1(input logic [4:0] wb, input logic inc, clr, input logic [5:0] th);
        @(negedge rclk);
        if1.rq2_wptr = g(wb); if1.rinc = inc; if1.rclr_err = clr; if1.rthresh = th;
        @(posedge rclk); #1;
    endtask

    initial begin
        logic [4:0] wb, rb;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 5);
        rst0_n = 1'b0; rst1_n = 1'b0;
        if0.rinc = 0; if0.rq2_wptr = '0; if0.rthresh = 6'd3; if0.rclr_err = 0;
        if1.rinc = 0; if1.rq2_wptr = '0; if1.rthresh = 6'd0; if1.rclr_err = 0;
        repeat (2) @(negedge rclk);
        rst0_n = 1'b1; rst1_n = 1'b1;
        #1;

        chk("rst0_rempty", if0.rempty, 1);
        chk("rst0_rlevel", if0.rlevel, 0);
        chk("rst0_rarempty", if0.rarempty, 1);
        chk("rst0_runderflow", if0.runderflow, 0);
        chk("rst0_rptr", if0.rptr, 0);

        //           wb inc clr th  rb e lvl a u
        vt[0]  = mk(0,  0, 0, 3,  0, 1, 0,  1, 0);
        vt[1]  = mk(1,  0, 0, 3,  0, 0, 1,  1, 0);
        vt[2]  = mk(2,  0, 0, 3,  0, 0, 2,  1, 0);
        vt[3]  = mk(2,  1, 0, 3,  1, 0, 1,  1, 0);
        vt[4]  = mk(2,  1, 0, 3,  2, 1, 0,  1, 0);
        vt[5]  = mk(2,  1, 0, 3,  2, 1, 0,  1, 1);
        vt[6]  = mk(2,  1, 1, 3,  2, 1, 0,  1, 1);
        vt[7]  = mk(2,  0, 1, 3,  2, 1, 0,  1, 0);
        vt[8]  = mk(3,  0, 0, 3,  2, 0, 1,  1, 0);
        vt[9]  = mk(4,  0, 0, 3,  2, 0, 2,  1, 0);
        vt[10] = mk(5,  0, 0, 3,  2, 0, 3,  1, 0);
        vt[11] = mk(6,  0, 0, 3,  2, 0, 4,  0, 0);
        vt[12] = mk(7,  0, 0, 3,  2, 0, 5,  0, 0);
        vt[13] = mk(8,  0, 0, 3,  2, 0, 6,  0, 0);
        vt[14] = mk(8,  0, 0, 0,  2, 0, 6,  0, 0);
        vt[15] = mk(8,  1, 0, 0,  3, 0, 5,  0, 0);
        vt[16] = mk(8,  1, 0, 0,  4, 0, 4,  0, 0);
        vt[17] = mk(8,  1, 0, 0,  5, 0, 3,  0, 0);
        vt[18] = mk(8,  1, 0, 0,  6, 0, 2,  0, 0);
        vt[19] = mk(8,  1, 0, 0,  7, 0, 1,  0, 0);
        vt[20] = mk(8,  1, 0, 0,  8, 1, 0,  1, 0);
        vt[21] = mk(24, 0, 0, 16, 8, 0, 16, 1, 0);
        vt[22] = mk(24, 0, 0, 15, 8, 0, 16, 0, 0);

        foreach (vt[i]) begin
            step0(vt[i].wb, vt[i].inc, vt[i].clr, vt[i].th);
            chk($sformatf("v%0d_raddr", i), if0.raddr, vt[i].rb[3:0]);
            chk($sformatf("v%0d_rptr", i), if0.rptr, g(vt[i].rb));
            chk($sformatf("v%0d_rempty", i), if0.rempty, vt[i].e);
            chk($sformatf("v%0d_rvalid", i), if0.rvalid, !vt[i].e);
            chk($sformatf("v%0d_rlevel", i), if0.rlevel, vt[i].lvl);
            chk($sformatf("v%0d_rarempty", i), if0.rarempty, vt[i].a);
            chk($sformatf("v%0d_runderflow", i), if0.runderflow, vt[i].u);
            chk($sformatf("v%0d_rdata", i), if0.rdata, mem[vt[i].rb[3:0]]);
        end

        // Wrap: drain 16, walk rbin to 31 using write+pop pairs, then 16 in / 16 out
        wb = 5'd24; rb = 5'd8;
        for (int k = 1; k <= 16; k++) begin
            rb = rb + 5'd1;
            step0(wb, 1, 0, 0);
            chk("drain_level", if0.rlevel, 6'(16 - k));
            chk("drain_rptr", if0.rptr, g(rb));
        end
        chk("drain_empty", if0.rempty, 1);
        wb = wb + 5'd1;
        step0(wb, 0, 0, 0);
        chk("pair_lvl_first", if0.rlevel, 1);
        for (int k = 0; k < 6; k++) begin
            wb = wb + 5'd1; rb = rb + 5'd1;
            step0(wb, 1, 0, 0);
            chk("pair_level_same_cycle", if0.rlevel, 1);
            chk("pair_rptr", if0.rptr, g(rb));
        end
        rb = rb + 5'd1;
        step0(wb, 1, 0, 0);
        chk("pre_wrap_rptr", if0.rptr, 5'b10000);
        chk("pre_wrap_empty", if0.rempty, 1);
        for (int k = 1; k <= 16; k++) begin
            wb = wb + 5'd1;
            step0(wb, 0, 0, 0);
            chk("wrap_fill_level", if0.rlevel, 6'(k));
        end
        for (int k = 1; k <= 16; k++) begin
            rb = rb + 5'd1;
            step0(wb, 1, 0, 0);
            chk("wrap_pop_rptr", if0.rptr, g(rb));
            chk("wrap_pop_level", if0.rlevel, 6'(16 - k));
        end
        chk("wrap_end_rptr", if0.rptr, g(5'd15));
        chk("wrap_end_empty", if0.rempty, 1);

        // FWFT instance
        chk("rst1_rvalid", if1.rvalid, 0);
        chk("rst1_rdata", if1.rdata, 0);
        chk("rst1_rlevel", if1.rlevel, 0);
        chk("rst1_rarempty", if1.rarempty, 1);
        step1(5'd1, 0, 0, 0);
        chk("f_t1_rvalid", if1.rvalid, 0);
        chk("f_t1_rlevel", if1.rlevel, 1);
        step1(5'd1, 0, 0, 0);
        chk("f_t2_rvalid", if1.rvalid, 1);
        chk("f_t2_rdata", if1.rdata, mem[0]);
        chk("f_t2_rlevel", if1.rlevel, 1);
        chk("f_t2_rarempty", if1.rarempty, 0);
        for (int w = 2; w <= 4; w++) begin
            step1(5'(w), 0, 0, 0);
            chk("f_fill_rlevel", if1.rlevel, 6'(w));
            chk("f_fill_rdata_hold", if1.rdata, mem[0]);
        end
        for (int k = 1; k <= 3; k++) begin
            step1(5'd4, 1, 0, 0);
            chk("f_stream_rvalid", if1.rvalid, 1);
            chk("f_stream_rdata", if1.rdata, mem[k]);
            chk("f_stream_rlevel", if1.rlevel, 6'(4 - k));
        end
        step1(5'd4, 1, 0, 0);
        chk("f_drain_rvalid", if1.rvalid, 0);
        chk("f_drain_rempty", if1.rempty, 1);
        chk("f_drain_rlevel", if1.rlevel, 0);
        chk("f_drain_rdata_hold", if1.rdata, mem[3]);
        chk("f_drain_no_underflow", if1.runderflow, 0);
        step1(5'd4, 1, 0, 0);
        chk("f_underflow_set", if1.runderflow, 1);
        chk("f_underflow_rptr", if1.rptr, g(5'd4));
        step1(5'd4, 0, 1, 0);
        chk("f_underflow_clr", if1.runderflow, 0);
        for (int w = 5; w <= 21; w++) begin
            step1(5'(w), 0, 0, 16);
            chk("f_load_rlevel", if1.rlevel, 6'(w - 4));
        end
        chk("f_full_rlevel", if1.rlevel, 17);
        chk("f_full_rarempty", if1.rarempty, 0);
        chk("f_full_rdata", if1.rdata, mem[4]);
        chk("f_full_rptr", if1.rptr, g(5'd5));

        @(negedge rclk); #2;
        rst1_n = 1'b0;
        #1;
        chk("f_mrst_rvalid", if1.rvalid, 0);
        chk("f_mrst_rempty", if1.rempty, 1);
        chk("f_mrst_rlevel", if1.rlevel, 0);
        chk("f_mrst_rdata", if1.rdata, 0);
        chk("f_mrst_rptr", if1.rptr, 0);
        chk("f_mrst_raddr", if1.raddr, 0);
        chk("f_mrst_rarempty", if1.rarempty, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rptr_level_ctrl.md
Name: rptr_level_ctrl

Overview:
Read-domain pointer and status controller for the async FIFO. It is a parametrised successor to the basic read-pointer/empty block and adds the following:
- binary fill level decoded from the synchronised Gray write pointer
- runtime-programmable almost-empty threshold
- sticky underflow flag
- optional first-word-fall-through (FWFT) output stage

It sits between the 2-flop wptr synchroniser, the dual-port RAM (asynchronous read at raddr) and the read-side user.

Parameters:
ADDRSIZE, 4, RAM address width; RAM depth = 2^ADDRSIZE.
DATASIZE, 8, data word width.
FWFT, 0, 0 = standard mode (RAM data passed through); 1 = registered first-word-fall-through stage.

Ports:
rclk  in  1  read clock
rrst_n  in  1  reset rrst_n, asynchronous, active-low
rinc  in  1  read/pop request
rq2_wptr  in  ADDRSIZE+1  synchronised Gray write pointer
rthresh  in  ADDRSIZE+2  almost-empty threshold in words (quasi-static)
rclr_err  in  1  clears runderflow
rmem_data  in  DATASIZE  RAM read data at raddr (combinational)
raddr  out  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0]
rptr  out  ADDRSIZE+1  registered Gray read pointer to the write domain
rdata  out  DATASIZE  read data to user
rvalid  out  1  rdata valid
rempty  out  1  user-visible empty (= ~rvalid)
rarempty  out  1  level <= rthresh
rlevel  out  ADDRSIZE+2  words available to the user
runderflow  out  1  sticky: rinc seen while empty

Behaviour:
- Reset (async assert, sync deassert, applied by rrst_n): outputs and internal state take these values.
  - rbin=0, rptr=0
  - mem_empty=1, rvalid=0, rempty=1, rarempty=1
  - rlevel=0, runderflow=0, rdata=0 (FWFT=1)
- Internal pop:
  - FWFT=0: pop = rinc & ~mem_empty.
  - FWFT=1: pop = ~mem_empty & (~rvalid | rinc).
- Pointer:
  - rbinnext = rbin + pop.
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Both registered into rbin/rptr; the pointer wraps modulo 2^(ADDRSIZE+1).
- mem_empty (internal reg) <= (rgraynext == rq2_wptr).
- wbin = Gray-to-binary(rq2_wptr), computed combinationally via an XOR prefix from the MSB.
- memlvl_next = (wbin - rbinnext) mod 2^(ADDRSIZE+1), giving a range of 0..2^ADDRSIZE.
- FWFT=0 mode:
  - rdata = rmem_data (combinational).
  - rvalid = ~mem_empty.
  - rlevel <= memlvl_next, zero-extended.
- FWFT=1 mode: two-state stage, IDLE (rvalid=0) and FULL (rvalid=1).
  - IDLE & ~mem_empty: rdata <= rmem_data, pop, go to FULL.
  - FULL & rinc & ~mem_empty: rdata <= rmem_data, pop, stay in FULL (back-to-back, no bubble).
  - FULL & rinc & mem_empty: go to IDLE; rdata holds its value.
  - FULL & ~rinc: hold.
  - rlevel <= memlvl_next + rvalid_next, maximum 2^ADDRSIZE+1.
- rempty = ~rvalid in both modes.
- rarempty <= (level_next <= rthresh), where level_next is the value being loaded into rlevel.
  - rthresh=0 makes rarempty equal to rempty.
  - rthresh >= max level keeps rarempty at 1 permanently.
- Latency, with a new write first visible on rq2_wptr in cycle t:
  - mem_empty falls at edge t+1.
  - FWFT=0: rvalid=1 during cycle t+1.
  - FWFT=1: pop occurs in cycle t+1; rvalid=1 and rdata loaded at edge t+2.
- Underflow:
  - rinc while rempty=1 sets runderflow at the next edge. The pointer does not move and no RAM read occurs.
  - runderflow stays set until rclr_err; if set and clear happen in the same cycle, set wins.
- Full wrap: rbin MSB toggles every 2^ADDRSIZE pops. Level arithmetic stays correct across the wrap, including at wbin=0 with rbin=2^(ADDRSIZE+1)-1.
- Pop and a new write in the same cycle: the level reflects both (the write via rq2_wptr, the pop via rbinnext).
- Mid-operation reset: all state returns immediately to reset values; rdata content is discarded.

Test Plan:
- FWFT=0, ADDRSIZE=4: reset, then step rq2_wptr through Gray 0→1→3 (wbin 0,1,2) -> rempty=1 until the edge after wptr=1; rlevel 0→1→2 one cycle after each change; rdata tracks rmem_data at raddr=0.
- Drain 2 words with rinc=1 for 3 cycles -> rbin 0→1→2 then holds; rempty=1 after the 2nd pop; the 3rd rinc sets runderflow=1; rclr_err together with another empty rinc keeps it at 1; rclr_err alone clears it.
- rthresh=3 with level ramping 0..6 -> rarempty=1 for levels 0..3 and 0 from level 4; rthresh=0 makes rarempty track rempty exactly.
- Wrap: preload rbin=rptr state near 31 via 30 write/read pairs, then 16 writes and 16 pops -> rlevel peaks at 16; rptr passes Gray 10000 (bin 31) to 00000 with no glitch; rempty=1 at the end.
- FWFT=1: single write visible at cycle t -> rvalid=1 and rdata=word0 at edge t+2; rlevel=1; a sustained rinc over 4 words gives one word per cycle with no bubble, then rvalid=0.
- FWFT=1 at full load (16 in RAM + 1 staged) -> rlevel=17; reset asserted mid-stream -> all outputs return to reset values immediately.
